// File: rtl/rvc_align_expander.sv
// Fetch realigner and RV32C expander: halfword buffer feeding a small output queue.
// Latency: word accepted at edge N, first instruction queued at edge N+1. Backpressure: full queue stalls extract.

// Generic synchronous FIFO with flush, used for the expanded-instruction queue.
// Latency: push visible at head one cycle later. Backpressure: caller must not push when full.
module rvc_ae_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic         full_o,
    output logic [W-1:0] head_dat_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;

    assign vld_o      = (cnt_q != '0);
    assign full_o     = (cnt_q == (AW+1)'(DEPTH));
    assign head_dat_o = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push_i) wr_q <= wr_q + AW'(1);
                if (pop_i)  rd_q <= rd_q + AW'(1);
                cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && !flush_i && push_i) mem_q[wr_q] <= push_dat_i;
    end
endmodule

// Splits fetch words into halfwords, reassembles 32-bit instructions and expands RVC.
// Latency: one cycle from buffer to queue; one instruction per cycle throughput.
// Backpressure: in_ready_o drops when two or more halfwords are waiting; queue full stalls extraction.
module rvc_align_expander #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter bit RVC_EN     = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rdy_i,
    input  logic              rollback_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_word_i,
    input  logic [ADDR_W-1:0] in_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_inst_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic              out_is_compressed_o,
    output logic              out_illegal_o
);
    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        logic              is_c;
        logic              ill;
    } out_ent_t;

    // Returns {illegal, expanded instruction}; illegal encodings expand to zero.
    function automatic logic [32:0] expand_rvc(input logic [15:0] c);
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [9:0]  imm10;
        logic [6:0]  imm7;
        logic [7:0]  imm8;
        rd    = c[11:7];
        rs2   = c[6:2];
        rdp   = {2'b01, c[4:2]};
        rs1p  = {2'b01, c[9:7]};
        imm7  = {c[5], c[12:10], c[6], 2'b00};
        imm10 = '0;
        imm8  = '0;
        ins   = '0;
        ill   = 1'b0;
        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin
                        imm10 = {c[10:7], c[12:11], c[5], c[6], 2'b00};
                        ill   = (imm10 == '0);
                        ins   = {2'b00, imm10, 5'd2, 3'b000, rdp, 7'h13};
                    end
                    3'b010:  ins = {5'b0, imm7, rs1p, 3'b010, rdp, 7'h03};
                    3'b110:  ins = {5'b0, imm7[6:5], rdp, rs1p, 3'b010, imm7[4:0], 7'h23};
                    default: ill = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: ins = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
                    3'b001, 3'b101:
                        ins = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                               {8{c[12]}}, (c[15] ? 5'd0 : 5'd1), 7'h6F};
                    3'b010: ins = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
                    3'b011: begin
                        if (rd == 5'd2) begin
                            imm10 = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
                            ill   = (imm10 == '0);
                            ins   = {{2{c[12]}}, imm10, 5'd2, 3'b000, 5'd2, 7'h13};
                        end else begin
                            ill = ({c[12], c[6:2]} == 6'd0);
                            ins = {{15{c[12]}}, c[6:2], rd, 7'h37};
                        end
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00: begin
                                ill = c[12];
                                ins = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                            end
                            2'b01: begin
                                ill = c[12];
                                ins = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                            end
                            2'b10: ins = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, 7'h13};
                            default: begin
                                ill = c[12];
                                case (c[6:5])
                                    2'b00:   ins = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                                    2'b01:   ins = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                                    2'b10:   ins = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                                    default: ins = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                                endcase
                            end
                        endcase
                    end
                    default:
                        ins = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13],
                               c[11:10], c[4:3], c[12], 7'h63};
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        ill = c[12];
                        ins = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'h13};
                    end
                    3'b010: begin
                        imm8 = {c[3:2], c[12], c[6:4], 2'b00};
                        ill  = (rd == 5'd0);
                        ins  = {4'b0000, imm8, 5'd2, 3'b010, rd, 7'h03};
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (rs2 == 5'd0) begin
                                ill = (rd == 5'd0);
                                ins = {12'b0, rd, 3'b000, 5'd0, 7'h67};
                            end else begin
                                ins = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                            end
                        end else if (rs2 == 5'd0 && rd == 5'd0) begin
                            ins = 32'h0010_0073;
                        end else if (rs2 == 5'd0) begin
                            ins = {12'b0, rd, 3'b000, 5'd1, 7'h67};
                        end else begin
                            ins = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
                        end
                    end
                    3'b110: begin
                        imm8 = {c[8:7], c[12:9], 2'b00};
                        ins  = {4'b0000, imm8[7:5], rs2, 5'd2, 3'b010, imm8[4:0], 7'h23};
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) ins = '0;
        return {ill, ins};
    endfunction

    logic [15:0]       hb_q [3];
    logic [15:0]       hb_d [3];
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic        accept, is32, can_ext, ext, pop, fifo_full, fifo_vld;
    logic [1:0]  used, added, cnt_rem;
    logic [32:0] exp_r;
    out_ent_t    push_ent, head_ent;

    always_comb begin
        in_ready_o = rst_ni & rdy_i & ~rollback_i & (cnt_q <= 2'd1);
        accept     = in_valid_i & in_ready_o;
        is32       = (hb_q[0][1:0] == 2'b11);
        can_ext    = is32 ? (cnt_q >= 2'd2) : (cnt_q >= 2'd1);
        pop        = fifo_vld & out_ready_i & rdy_i;
        ext        = rdy_i & ~rollback_i & can_ext & (~fifo_full | pop);
        used       = ext ? (is32 ? 2'd2 : 2'd1) : 2'd0;
        cnt_rem    = cnt_q - used;

        exp_r         = expand_rvc(hb_q[0]);
        push_ent.pc   = pc_q;
        push_ent.is_c = ~is32;
        if (is32) begin
            push_ent.inst = {hb_q[1], hb_q[0]};
            push_ent.ill  = 1'b0;
        end else if (RVC_EN) begin
            push_ent.inst = exp_r[31:0];
            push_ent.ill  = exp_r[32];
        end else begin
            push_ent.inst = '0;
            push_ent.ill  = 1'b1;
        end

        hb_d = hb_q;
        case (used)
            2'd1: begin
                hb_d[0] = hb_q[1];
                hb_d[1] = hb_q[2];
                hb_d[2] = '0;
            end
            2'd2: begin
                hb_d[0] = hb_q[2];
                hb_d[1] = '0;
                hb_d[2] = '0;
            end
            default: ;
        endcase

        // Appends land behind whatever survives this cycle's extract.
        added = 2'd0;
        if (accept) begin
            if (cnt_q == 2'd0 && in_pc_i[1]) begin
                hb_d[0] = in_word_i[31:16];
                added   = 2'd1;
            end else if (cnt_rem == 2'd0) begin
                hb_d[0] = in_word_i[15:0];
                hb_d[1] = in_word_i[31:16];
                added   = 2'd2;
            end else begin
                hb_d[1] = in_word_i[15:0];
                hb_d[2] = in_word_i[31:16];
                added   = 2'd2;
            end
        end

        cnt_d = rollback_i ? 2'd0 : (cnt_rem + added);

        pc_d = pc_q;
        if (accept && cnt_q == 2'd0) begin
            pc_d = in_pc_i;
        end else if (ext) begin
            pc_d = pc_q + (is32 ? ADDR_W'(4) : ADDR_W'(2));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hb_q  <= '{default: '0};
            cnt_q <= 2'd0;
            pc_q  <= '0;
        end else if (rdy_i) begin
            hb_q  <= hb_d;
            cnt_q <= cnt_d;
            pc_q  <= pc_d;
        end
    end

    rvc_ae_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(out_ent_t))
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (rdy_i),
        .flush_i    (rollback_i),
        .push_i     (ext),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .vld_o      (fifo_vld),
        .full_o     (fifo_full),
        .head_dat_o (head_ent)
    );

    // Payload is masked while the queue is empty so stale entries never leak out.
    always_comb begin
        out_valid_o         = fifo_vld;
        out_inst_o          = fifo_vld ? head_ent.inst : 32'h0;
        out_pc_o            = fifo_vld ? head_ent.pc   : '0;
        out_is_compressed_o = fifo_vld & head_ent.is_c;
        out_illegal_o       = fifo_vld & head_ent.ill;
    end
endmodule

// File: tb/tb_rvc_align_expander.sv
// Directed bench for rvc_align_expander: expansion vectors, realignment, backpressure, flush, freeze, reset.
module tb_rvc_align_expander;
    logic        clk, rst_n, rdy, rollback;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_word, in_pc, out_inst, out_pc;
    logic        out_is_c, out_ill;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, out_is_c0, out_ill0, rollback0;
    logic [31:0] in_word0, in_pc0, out_inst0, out_pc0;

    int npass = 0;
    int nfail = 0;
    int wi, ri;
    logic acc;
    logic [31:0] words [4];

    rvc_align_expander #(.FIFO_DEPTH(4), .ADDR_W(32), .RVC_EN(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .rollback_i(rollback),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_word_i(in_word), .in_pc_i(in_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_inst_o(out_inst),
        .out_pc_o(out_pc), .out_is_compressed_o(out_is_c), .out_illegal_o(out_ill)
    );

    rvc_align_expander #(.FIFO_DEPTH(4), .ADDR_W(32), .RVC_EN(1'b0)) u_dut_norvc (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .rollback_i(rollback0),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_word_i(in_word0), .in_pc_i(in_pc0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_inst_o(out_inst0),
        .out_pc_o(out_pc0), .out_is_compressed_o(out_is_c0), .out_illegal_o(out_ill0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_word  = w;
        in_pc    = pc;
        #1;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk("send_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic c, input logic ill);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_inst"}, out_inst, inst);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_c"}, out_is_c, c);
        chk({tag, "_ill"}, out_ill, ill);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
        in_valid = 1'b0; in_word = '0; in_pc = '0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_word0 = '0; in_pc0 = '0; out_ready0 = 1'b1; rollback0 = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_c", out_is_c, 0);
        chk("rst_out_ill", out_ill, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Two c.li in one word; check first-instruction latency.
        send(32'h4505_4501, 32'h0);
        chk("lat_edge_n", out_valid, 0);
        tick();
        chk("lat_edge_n1", out_valid, 1);
        pop_chk("t1a", 32'h0000_0513, 32'h0, 1'b1, 1'b0);
        pop_chk("t1b", 32'h0010_0513, 32'h2, 1'b1, 1'b0);

        // 32-bit instruction straddling two fetch words.
        send(32'h0093_0001, 32'h0);
        send(32'h4501_0010, 32'h4);
        pop_chk("t2a", 32'h0000_0013, 32'h0, 1'b1, 1'b0);
        pop_chk("t2b", 32'h0010_0093, 32'h2, 1'b0, 1'b0);
        pop_chk("t2c", 32'h0000_0513, 32'h6, 1'b1, 1'b0);

        // Expansion vectors and illegal encodings.
        send(32'h0000_8C05, 32'h10);
        pop_chk("c_sub", 32'h4094_0433, 32'h10, 1'b1, 1'b0);
        pop_chk("zero_hw", 32'h0, 32'h12, 1'b1, 1'b1);
        send(32'h852E_8082, 32'h20);
        pop_chk("c_jr", 32'h0000_8067, 32'h20, 1'b1, 1'b0);
        pop_chk("c_mv", 32'h00B0_0533, 32'h22, 1'b1, 1'b0);
        send(32'h6101_1006, 32'h30);
        pop_chk("slli_sh5", 32'h0, 32'h30, 1'b1, 1'b1);
        pop_chk("addi16sp_0", 32'h0, 32'h32, 1'b1, 1'b1);

        // RVC disabled: any 16-bit encoding is illegal.
        in_valid0 = 1'b1; in_word0 = 32'h4501_4501; in_pc0 = 32'h40;
        #1;
        chk("norvc_in_ready", in_ready0, 1);
        tick();
        in_valid0 = 1'b0;
        tick();
        chk("norvc_vld", out_valid0, 1);
        chk("norvc_ill", out_ill0, 1);
        chk("norvc_inst", out_inst0, 0);
        chk("norvc_pc", out_pc0, 32'h40);
        chk("norvc_c", out_is_c0, 1);

        // Backpressure: consumer stalled while 8 c.li halfwords stream in.
        words[0] = 32'h4505_4501;
        words[1] = 32'h450D_4509;
        words[2] = 32'h4515_4511;
        words[3] = 32'h451D_4519;
        wi = 0;
        ri = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (wi < 4);
            in_word  = words[wi % 4];
            in_pc    = 32'h100 + 32'(4 * wi);
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) wi++;
        end
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_words_taken", wi, 3);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", out_inst, 32'h0000_0513);
        for (int cyc = 0; cyc < 40 && ri < 8; cyc++) begin
            in_valid  = (wi < 4);
            in_word   = words[wi % 4];
            in_pc     = 32'h100 + 32'(4 * wi);
            out_ready = 1'b1;
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("stream_inst", out_inst, 32'h0000_0513 + (32'(ri) << 20));
                chk("stream_pc", out_pc, 32'h100 + 32'(2 * ri));
                ri++;
            end
            tick();
            if (acc) wi++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", ri, 8);
        chk("stream_words", wi, 4);
        tick();
        tick();
        chk("stream_no_dup", out_valid, 0);

        // Rollback with half a 32-bit instruction buffered and an entry queued.
        send(32'h0093_0001, 32'h200);
        tick();
        chk("rb_pre_vld", out_valid, 1);
        rollback = 1'b1; in_valid = 1'b1; in_word = 32'h1234_5678; in_pc = 32'h300; out_ready = 1'b1;
        #1;
        chk("rb_in_ready", in_ready, 0);
        tick();
        rollback = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rb_flushed", out_valid, 0);
        send(32'h4509_0093, 32'h102);
        pop_chk("rb_resume", 32'h0020_0513, 32'h102, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("rb_tail_empty", out_valid, 0);

        // Freeze with rdy low.
        send(32'h4505_4501, 32'h300);
        rdy = 1'b0; in_valid = 1'b1; in_word = 32'h450D_4509; in_pc = 32'h304; out_ready = 1'b1;
        #1;
        chk("frz_in_ready", in_ready, 0);
        tick();
        tick();
        tick();
        chk("frz_no_extract", out_valid, 0);
        rdy = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("frz_resume_vld", out_valid, 1);
        rdy = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("frz_hold_inst", out_inst, 32'h0000_0513);
        chk("frz_hold_pc", out_pc, 32'h300);
        rdy = 1'b1; out_ready = 1'b0;
        pop_chk("frz_a", 32'h0000_0513, 32'h300, 1'b1, 1'b0);
        pop_chk("frz_b", 32'h0010_0513, 32'h302, 1'b1, 1'b0);

        // Asynchronous reset mid-operation.
        send(32'h4505_4501, 32'h400);
        tick();
        tick();
        chk("arst_pre_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", out_valid, 0);
        chk("arst_inst", out_inst, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_c", out_is_c, 0);
        chk("arst_ill", out_ill, 0);
        chk("arst_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_after_vld", out_valid, 0);

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end
endmodule
